ysyx_rf_wb_sched: RTL and testbench

- Write-back scheduler and scoreboard for the single-write-port register file in the multi-cycle NPC core.
- Arbitrates ALU and LSU write-back requests onto the one register-file write port, with round-robin fairness.
- Tracks a pending-write busy bit per architectural register and produces issue/RAW stall signals for IDU.

---
 rtl/ysyx_rf_wb_sched.sv | 116 +++++++++++
 tb/tb_ysyx_rf_wb_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_rf_wb_sched.sv
// Write-back scheduler and register scoreboard for the single-write-port register file.
// Optional macro YSYX_RF_BYPASS_EN adds a same-cycle bypass of the committing write to IDU sources.
module ysyx_rf_wb_sched #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            raw_stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [DW-1:0]   lsu_data,
    output logic            lsu_ready,
    output logic            rf_wr_en,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic [NREG-1:0] busy,
    output logic            wb_err
`ifdef YSYX_RF_BYPASS_EN
    ,
    output logic            byp1_en,
    output logic            byp2_en,
    output logic [DW-1:0]   byp_data
`endif
);

    localparam logic RR_ALU = 1'b0;
    localparam logic RR_LSU = 1'b1;

    logic            rr_last;
    logic            gnt;
    logic [AW-1:0]   gnt_rd;
    logic [DW-1:0]   gnt_data;
    logic [NREG-1:0] busy_nxt;
    logic            s1_hz;
    logic            s2_hz;

    // Round-robin arbitration: on a tie the requester not granted last time wins
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (alu_valid && lsu_valid) begin
            alu_ready = (rr_last == RR_LSU);
            lsu_ready = (rr_last == RR_ALU);
        end else begin
            alu_ready = alu_valid;
            lsu_ready = lsu_valid;
        end
        gnt      = alu_ready || lsu_ready;
        gnt_rd   = lsu_ready ? lsu_rd : alu_rd;
        gnt_data = lsu_ready ? lsu_data : alu_data;
    end

    // Scoreboard: clear on register-file commit, set on accepted issue
    always_comb begin
        iss_ready = !((iss_rd != '0) && busy[iss_rd]);
        busy_nxt  = busy;
        if (rf_wr_en) begin
            busy_nxt[rf_waddr] = 1'b0;
        end
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

`ifdef YSYX_RF_BYPASS_EN
    always_comb begin
        byp1_en  = rf_wr_en && (rs1 == rf_waddr) && (rs1 != '0);
        byp2_en  = rf_wr_en && (rs2 == rf_waddr) && (rs2 != '0);
        byp_data = rf_wdata;
        s1_hz    = (rs1 != '0) && busy[rs1] && !byp1_en;
        s2_hz    = (rs2 != '0) && busy[rs2] && !byp2_en;
    end
`else
    always_comb begin
        s1_hz = (rs1 != '0) && busy[rs1];
        s2_hz = (rs2 != '0) && busy[rs2];
    end
`endif

    assign raw_stall = s1_hz || s2_hz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last  <= RR_LSU;
            rf_wr_en <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            rf_wr_en <= gnt && (gnt_rd != '0);
            if (gnt) begin
                rr_last  <= lsu_ready ? RR_LSU : RR_ALU;
                rf_waddr <= gnt_rd;
                rf_wdata <= gnt_data;
                if ((gnt_rd != '0) && !busy[gnt_rd]) begin
                    wb_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_rf_wb_sched.sv
// Self-checking bench for ysyx_rf_wb_sched: directed scenarios then random traffic against a reference model.
module tb_ysyx_rf_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  rs1, rs2;
    logic        raw_stall;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic        rf_wr_en;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic        wb_err;
`ifdef YSYX_RF_BYPASS_EN
    logic        byp1_en, byp2_en;
    logic [31:0] byp_data;
`endif

    ysyx_rf_wb_sched dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .raw_stall(raw_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_wr_en(rf_wr_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .wb_err(wb_err)
`ifdef YSYX_RF_BYPASS_EN
        , .byp1_en(byp1_en), .byp2_en(byp2_en), .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one flag per register, who won last, and the pending register-file write
    bit          m_busy[32];
    int          m_last;        // 1 = ALU won last, 2 = LSU won last
    bit          m_wr_en;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;
    int          e_gnt;         // 0 none, 1 ALU, 2 LSU (for the current inputs)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_last  = 2;
        m_wr_en = 1'b0;
        m_waddr = 0;
        m_wdata = '0;
        m_err   = 1'b0;
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit src_hazard(input int r);
        bit byp;
`ifdef YSYX_RF_BYPASS_EN
        byp = m_wr_en && (r == m_waddr);
`else
        byp = 1'b0;
`endif
        return (r != 0) && m_busy[r] && !byp;
    endfunction

    // Settle combinational outputs, then compare every output with the model
    task automatic check_all();
        bit e_iss_ready;
        #2;
        if (alu_valid && lsu_valid) e_gnt = (m_last == 2) ? 1 : 2;
        else if (alu_valid)         e_gnt = 1;
        else if (lsu_valid)         e_gnt = 2;
        else                        e_gnt = 0;
        e_iss_ready = !((int'(iss_rd) != 0) && m_busy[iss_rd]);
        chk("iss_ready", 32'(iss_ready), 32'(e_iss_ready));
        chk("raw_stall", 32'(raw_stall), 32'(src_hazard(int'(rs1)) || src_hazard(int'(rs2))));
        chk("alu_ready", 32'(alu_ready), 32'(e_gnt == 1));
        chk("lsu_ready", 32'(lsu_ready), 32'(e_gnt == 2));
        chk("rf_wr_en",  32'(rf_wr_en),  32'(m_wr_en));
        chk("rf_waddr",  32'(rf_waddr),  32'(m_waddr));
        chk("rf_wdata",  rf_wdata,       m_wdata);
        chk("busy",      busy,           model_busy_vec());
        chk("wb_err",    32'(wb_err),    32'(m_err));
`ifdef YSYX_RF_BYPASS_EN
        chk("byp1_en",  32'(byp1_en), 32'(m_wr_en && int'(rs1) == m_waddr && rs1 != 0));
        chk("byp2_en",  32'(byp2_en), 32'(m_wr_en && int'(rs2) == m_waddr && rs2 != 0));
        chk("byp_data", byp_data, m_wdata);
`endif
    endtask

    // Advance one clock edge, updating the model from the inputs seen during the cycle
    task automatic tick();
        bit          nb[32];
        bit          acc;
        int          rd;
        logic [31:0] d;
        nb  = m_busy;
        acc = iss_valid && !((int'(iss_rd) != 0) && m_busy[iss_rd]);
        if (m_wr_en) nb[m_waddr] = 1'b0;
        if (acc && iss_rd != 0) nb[iss_rd] = 1'b1;
        @(posedge clk);
        #1;
        if (e_gnt != 0) begin
            rd = (e_gnt == 1) ? int'(alu_rd) : int'(lsu_rd);
            d  = (e_gnt == 1) ? alu_data : lsu_data;
            if (rd != 0 && !m_busy[rd]) m_err = 1'b1;
            m_wr_en = (rd != 0);
            m_waddr = rd;
            m_wdata = d;
            m_last  = e_gnt;
        end else begin
            m_wr_en = 1'b0;
        end
        m_busy = nb;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1; iss_rd = rd;
        check_all(); tick();
        iss_valid = 0; iss_rd = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        chk("reset_rf_wr_en", 32'(rf_wr_en), 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_wb_err", 32'(wb_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Issue x5, then ALU write-back to x5
        issue(5'd5);
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        check_all();
        chk("t1_busy", busy, 32'h20);
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 0;
        check_all();
        chk("t1_wr_en", 32'(rf_wr_en), 32'd1);
        chk("t1_waddr", 32'(rf_waddr), 32'd5);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        check_all();
        chk("t1_busy_clr", busy, 32'd0);
        tick();

        // Round-robin between ALU and LSU
        do_reset();
        issue(5'd3);
        issue(5'd4);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
        check_all();
        chk("t2_alu_first", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 0;
        check_all();
        chk("t2_lsu_next", 32'(lsu_ready), 32'd1);
        chk("t2_waddr3", 32'(rf_waddr), 32'd3);
        tick();
        lsu_valid = 0;
        check_all();
        chk("t2_waddr4", 32'(rf_waddr), 32'd4);
        tick();
        alu_valid = 1; lsu_valid = 1;
        check_all();
        chk("t2_alu_again", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 0;
        check_all(); tick();
        lsu_valid = 0;
        check_all(); tick();

        // WAW stall and RAW stall on x7
        do_reset();
        issue(5'd7);
        iss_valid = 1; iss_rd = 7; rs1 = 7;
        check_all();
        chk("t3_waw", 32'(iss_ready), 32'd0);
        chk("t3_raw", 32'(raw_stall), 32'd1);
        tick();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        check_all();
        chk("t3_waw_gnt", 32'(iss_ready), 32'd0);
        tick();
        alu_valid = 0;
        check_all();
        chk("t3_waw_commit", 32'(iss_ready), 32'd0);
`ifdef YSYX_RF_BYPASS_EN
        chk("t3_raw_commit", 32'(raw_stall), 32'd0);
`else
        chk("t3_raw_commit", 32'(raw_stall), 32'd1);
`endif
        tick();
        check_all();
        chk("t3_waw_release", 32'(iss_ready), 32'd1);
        tick();
        iss_valid = 1; iss_rd = 0; rs1 = 0; rs2 = 0;
        check_all();
        chk("t3_x0_nostall", 32'(raw_stall), 32'd0);
        tick();
        iss_valid = 0;
        check_all();
        chk("t3_x0_busy", busy, 32'h80);
        tick();

        // x0 write-back and sticky wb_err
        do_reset();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        check_all();
        chk("t4_x0_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 0;
        check_all();
        chk("t4_x0_wr_en", 32'(rf_wr_en), 32'd0);
        chk("t4_x0_err", 32'(wb_err), 32'd0);
        tick();
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
        check_all(); tick();
        lsu_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check_all();
            chk("t4_err_sticky", 32'(wb_err), 32'd1);
            tick();
        end

        // Source matching the committing write
        do_reset();
        issue(5'd6);
        alu_valid = 1; alu_rd = 6; alu_data = 32'hAA;
        check_all(); tick();
        alu_valid = 0; rs2 = 6;
        check_all();
`ifdef YSYX_RF_BYPASS_EN
        chk("t5_raw", 32'(raw_stall), 32'd0);
        chk("t5_byp2", 32'(byp2_en), 32'd1);
        chk("t5_bdata", byp_data, 32'hAA);
`else
        chk("t5_raw", 32'(raw_stall), 32'd1);
`endif
        tick();
        rs2 = 0;

        // Asynchronous reset in the middle of a commit
        issue(5'd2);
        alu_valid = 1; alu_rd = 2; alu_data = 32'h2222;
        check_all(); tick();
        alu_valid = 0; iss_valid = 1; iss_rd = 8;
        check_all();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("t6_rst_waddr", 32'(rf_waddr), 32'd0);
        chk("t6_rst_wdata", rf_wdata, 32'd0);
        chk("t6_rst_busy", busy, 32'd0);
        chk("t6_rst_err", 32'(wb_err), 32'd0);
        model_reset();
        idle_inputs();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
        chk("t6_first_alu", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 0;
        check_all(); tick();
        lsu_valid = 0;
        check_all(); tick();

        // Random traffic; a pending request is held until it is granted
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!alu_valid) begin
                alu_valid = ($urandom_range(0, 2) == 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!lsu_valid) begin
                lsu_valid = ($urandom_range(0, 2) == 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 1) == 0);
            iss_rd    = 5'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            check_all();
            tick();
            if (e_gnt == 1) alu_valid = 0;
            if (e_gnt == 2) lsu_valid = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
